// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: mode codes, state
// encodings and the stale-flag guard length.
package acq_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;

  localparam int GUARD_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GUARD,
    ST_WAIT_FULL,
    ST_STOP,
    ST_FRAME,
    ST_DONE
  } acq_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_WAIT_DATA,
    RD_SEND
  } rd_state_e;

  // Mode 3 falls through to single-shot behaviour.
  function automatic logic rearm_mode(input logic [1:0] m);
    return (m == MODE_NORMAL) || (m == MODE_AUTO);
  endfunction

endpackage

// File: rtl/acq_sequencer_frame_reader.sv
// Streams one frame out of the circular sample RAM: latches the start address
// and length, reads one sample at a time and holds it until tx_control accepts.
module frame_reader
  import acq_pkg::*;
#(
  parameter int BITS_ADC = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_W-1:0]   wr_ptr,
  input  logic [ADDR_W:0]     frame_len,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [BITS_ADC-1:0] ram_rd_data,
  output logic [BITS_ADC-1:0] tx_data,
  output logic                tx_rdy,
  output logic                tx_eof,
  input  logic                tx_ack,
  output logic                done
);

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W:0]       rem_q, rem_d;
  logic [BITS_ADC-1:0]   data_q, data_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      RD_IDLE: begin
        if (load) begin
          // A full-depth frame has zero low bits, so it starts at wr_ptr.
          base_d  = wr_ptr - frame_len[ADDR_W-1:0];
          rem_d   = frame_len;
          state_d = RD_READ;
        end
      end
      RD_READ:      state_d = RD_WAIT_DATA;
      RD_WAIT_DATA: begin
        data_d  = ram_rd_data;
        state_d = RD_SEND;
      end
      RD_SEND: begin
        if (tx_ack) begin
          base_d  = base_q + ADDR_W'(1);
          rem_d   = rem_q - REM_ONE;
          state_d = (rem_q == REM_ONE) ? RD_IDLE : RD_READ;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      base_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  assign ram_rd_en   = (state_q == RD_READ);
  assign ram_rd_addr = base_q;
  assign tx_data     = data_q;
  assign tx_rdy      = (state_q == RD_SEND);
  assign tx_eof      = (state_q == RD_SEND) && (rem_q == REM_ONE);
  assign done        = (state_q == RD_SEND) && tx_ack && (rem_q == REM_ONE);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition scheduler for one ADC channel: arms the buffer controller, waits
// for a full triggered capture (or auto timeout), then streams the frame out.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int BITS_ADC = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rqst_start,
  input  logic                rqst_stop,
  input  logic [1:0]          mode,
  input  logic [15:0]         num_samples,
  input  logic [15:0]         auto_timeout,
  input  logic                input_rdy,
  output logic                bc_start,
  output logic                bc_stop,
  input  logic [1:0]          bc_status,
  input  logic [ADDR_W-1:0]   wr_ptr,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [BITS_ADC-1:0] ram_rd_data,
  output logic [BITS_ADC-1:0] tx_data,
  output logic                tx_rdy,
  output logic                tx_eof,
  input  logic                tx_ack,
  output logic                busy,
  output logic                timed_out
);

  localparam logic [16:0] DEPTH      = 17'(2 ** ADDR_W);
  localparam logic [1:0]  GUARD_LAST = 2'(GUARD_CYCLES - 1);

  acq_state_e        state_q;
  logic              bc_start_q, bc_stop_q, timed_out_q, stop_pend_q;
  logic [15:0]       tmo_cnt_q;
  logic [1:0]        guard_cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic [16:0]       ns_ext;
  logic              rd_done;

  assign ns_ext      = {1'b0, num_samples};
  assign len_clamped = (ns_ext > DEPTH) ? DEPTH[ADDR_W:0] : ns_ext[ADDR_W:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bc_start_q  <= 1'b0;
      bc_stop_q   <= 1'b0;
      timed_out_q <= 1'b0;
      stop_pend_q <= 1'b0;
      tmo_cnt_q   <= '0;
      guard_cnt_q <= '0;
      len_q       <= '0;
    end else begin
      bc_start_q <= 1'b0;
      bc_stop_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rqst_start && !rqst_stop && (num_samples != 16'd0)) begin
            state_q    <= ST_ARM;
            bc_start_q <= 1'b1;
            len_q      <= len_clamped;
          end
        end
        ST_ARM: begin
          tmo_cnt_q   <= '0;
          timed_out_q <= 1'b0;
          guard_cnt_q <= '0;
          stop_pend_q <= 1'b0;
          if (rqst_stop) begin
            state_q   <= ST_IDLE;
            bc_stop_q <= 1'b1;
          end else begin
            state_q <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          guard_cnt_q <= guard_cnt_q + 2'd1;
          if (rqst_stop) begin
            state_q   <= ST_IDLE;
            bc_stop_q <= 1'b1;
          end else if (guard_cnt_q == GUARD_LAST) begin
            state_q <= ST_WAIT_FULL;
          end
        end
        ST_WAIT_FULL: begin
          if (rqst_stop) begin
            state_q   <= ST_IDLE;
            bc_stop_q <= 1'b1;
          end else if (bc_status == 2'b11) begin
            state_q   <= ST_STOP;
            bc_stop_q <= 1'b1;
          end else if ((mode == MODE_AUTO) && (auto_timeout != 16'd0)) begin
            // Count saturates at the limit so a late buffer_full still fires.
            if ((tmo_cnt_q == auto_timeout) && bc_status[0]) begin
              timed_out_q <= 1'b1;
              state_q     <= ST_STOP;
              bc_stop_q   <= 1'b1;
            end else if (input_rdy && (tmo_cnt_q != auto_timeout)) begin
              tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
          end
        end
        ST_STOP: begin
          if (rqst_stop) stop_pend_q <= 1'b1;
          state_q <= ST_FRAME;
        end
        ST_FRAME: begin
          if (rqst_stop) stop_pend_q <= 1'b1;
          if (rd_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (rearm_mode(mode) && !stop_pend_q && !rqst_stop) begin
            state_q    <= ST_ARM;
            bc_start_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  frame_reader #(
    .BITS_ADC (BITS_ADC),
    .ADDR_W   (ADDR_W)
  ) u_reader (
    .clk         (clk),
    .rst         (rst),
    .load        (state_q == ST_STOP),
    .wr_ptr      (wr_ptr),
    .frame_len   (len_q),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .tx_eof      (tx_eof),
    .tx_ack      (tx_ack),
    .done        (rd_done)
  );

  assign bc_start  = bc_start_q;
  assign bc_stop   = bc_stop_q;
  assign timed_out = timed_out_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomized scoreboard bench for acq_sequencer with a small sample RAM
// (ADDR_W=4) so wrap-around and length clamping are cheap to reach.
module tb_acq_sequencer;

  localparam int BITS_ADC = 8;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;

  logic                clk, rst;
  logic                rqst_start, rqst_stop, input_rdy, tx_ack;
  logic [1:0]          mode, bc_status;
  logic [15:0]         num_samples, auto_timeout;
  logic [ADDR_W-1:0]   wr_ptr, ram_rd_addr;
  logic [BITS_ADC-1:0] ram_rd_data, tx_data;
  logic                bc_start, bc_stop, ram_rd_en, tx_rdy, tx_eof, busy, timed_out;

  acq_sequencer #(.BITS_ADC(BITS_ADC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rqst_start(rqst_start), .rqst_stop(rqst_stop),
    .mode(mode), .num_samples(num_samples), .auto_timeout(auto_timeout),
    .input_rdy(input_rdy), .bc_start(bc_start), .bc_stop(bc_stop),
    .bc_status(bc_status), .wr_ptr(wr_ptr), .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .tx_data(tx_data),
    .tx_rdy(tx_rdy), .tx_eof(tx_eof), .tx_ack(tx_ack), .busy(busy),
    .timed_out(timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BITS_ADC-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  typedef struct packed {
    logic [BITS_ADC-1:0] data;
    logic                eof;
    logic                to;
  } beat_t;

  beat_t             beat_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: the frame is the last n (clamped to depth) samples before wr_ptr.
  task automatic push_frame(input int n, input int wr, input bit to);
    int len;
    int base;
    int a;
    beat_t b;
    len  = (n > DEPTH) ? DEPTH : n;
    base = (wr - len + DEPTH) % DEPTH;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      addr_q.push_back(ADDR_W'(a));
      b.data = mem[a];
      b.eof  = (i == len - 1);
      b.to   = to;
      beat_q.push_back(b);
    end
  endtask

  int    cyc = 0;
  int    bc_start_cyc = 0, bc_stop_cyc = 0, beats_seen = 0, eof_seen = 0;
  int    last_ack_cyc = 0;
  bit    ack_pending = 0;
  logic  prev_rdy = 0, prev_ack = 0, prev_eof = 0, prev_rst = 1;
  logic [BITS_ADC-1:0] prev_data = '0;
  beat_t mb;
  logic [ADDR_W-1:0] ea;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ack_pending = 0;
    end else begin
      if (bc_start) bc_start_cyc++;
      if (bc_stop)  bc_stop_cyc++;
      if (ram_rd_en) begin
        if (addr_q.size() == 0) check("rd_unexpected", 32'(ram_rd_addr), 32'hFFFF);
        else begin
          ea = addr_q.pop_front();
          check("ram_rd_addr", 32'(ram_rd_addr), 32'(ea));
        end
      end
      if (prev_rdy && !prev_ack && !prev_rst) begin
        check("tx_rdy_hold", 32'(tx_rdy), 32'd1);
        check("tx_data_hold", 32'(tx_data), 32'(prev_data));
        check("tx_eof_hold", 32'(tx_eof), 32'(prev_eof));
      end
      if (tx_rdy && !prev_rdy && ack_pending) begin
        check("ack_to_rdy", 32'(cyc - last_ack_cyc), 32'd3);
        ack_pending = 0;
      end
      if (tx_rdy && tx_ack) begin
        if (beat_q.size() == 0) check("beat_unexpected", 32'(tx_data), 32'hFFFF);
        else begin
          mb = beat_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(mb.data));
          check("tx_eof", 32'(tx_eof), 32'(mb.eof));
          check("timed_out", 32'(timed_out), 32'(mb.to));
        end
        beats_seen++;
        if (tx_eof) begin
          eof_seen++;
          ack_pending = 0;
        end else begin
          ack_pending  = 1;
          last_ack_cyc = cyc;
        end
      end
    end
    prev_rdy  = tx_rdy;
    prev_ack  = tx_ack;
    prev_eof  = tx_eof;
    prev_data = tx_data;
    prev_rst  = rst;
  end

  // tx_control model: acks after a delay, optionally asserts stray acks while idle.
  int ack_delay = 0;
  bit ack_rand = 1;
  bit spurious = 1;
  initial begin
    int cnt;
    int cur_delay;
    cnt = 0;
    cur_delay = 0;
    tx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ack = 1'b0;
      if (rst) cnt = 0;
      else if (tx_rdy) begin
        if (cnt >= cur_delay) begin
          tx_ack = 1'b1;
          cnt = 0;
          cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
        end else cnt++;
      end else begin
        cnt = 0;
        cur_delay = ack_rand ? cur_delay : ack_delay;
        if (spurious && ($urandom_range(0, 3) == 0)) tx_ack = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    rqst_start = 1'b1; tick(1); rqst_start = 1'b0;
  endtask

  task automatic pulse_stop();
    rqst_stop = 1'b1; tick(1); rqst_stop = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int t = 0;
    while (bc_start_cyc < target && t < 200) begin tick(1); t++; end
    check("bc_start_seen", 32'(bc_start_cyc >= target), 32'd1);
  endtask

  task automatic wait_eofs(input int target);
    int t = 0;
    while (eof_seen < target && t < 3000) begin tick(1); t++; end
    check("frame_done", 32'(eof_seen >= target), 32'd1);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = BITS_ADC'($urandom);
  endtask

  task automatic run_frame(input logic [1:0] m, input int n, input int wr, input int trig_dly);
    int s0, e0;
    mode = m; num_samples = 16'(n); wr_ptr = ADDR_W'(wr); bc_status = 2'b00;
    fill_mem();
    s0 = bc_start_cyc; e0 = eof_seen;
    pulse_start();
    wait_starts(s0 + 1);
    tick(trig_dly);
    push_frame(n, wr, 1'b0);
    bc_status = 2'b11;
    wait_eofs(e0 + 1);
    bc_status = 2'b00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bc_start"}, 32'(bc_start), 32'd0);
    check({tag, "_bc_stop"}, 32'(bc_stop), 32'd0);
    check({tag, "_ram_rd_en"}, 32'(ram_rd_en), 32'd0);
    check({tag, "_ram_rd_addr"}, 32'(ram_rd_addr), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_rdy"}, 32'(tx_rdy), 32'd0);
    check({tag, "_tx_eof"}, 32'(tx_eof), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timed_out"}, 32'(timed_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0, e0, b0, n, wr;
    rst = 1'b1; rqst_start = 1'b0; rqst_stop = 1'b0; input_rdy = 1'b0;
    mode = 2'd0; num_samples = 16'd4; auto_timeout = 16'd0; bc_status = 2'b00;
    wr_ptr = '0; ram_rd_data = '0;
    fill_mem();
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Single shot, 4 samples ending at wr_ptr=10.
    s0 = bc_start_cyc; p0 = bc_stop_cyc;
    run_frame(2'd0, 4, 10, 20);
    tick(20);
    check("single_starts", 32'(bc_start_cyc - s0), 32'd1);
    check("single_stops", 32'(bc_stop_cyc - p0), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Address wrap: 13,14,15,0,1.
    run_frame(2'd0, 5, 2, 4);
    tick(5);

    // Auto mode timeout on buffer_full without trigger.
    mode = 2'd2; auto_timeout = 16'd8; num_samples = 16'd6; wr_ptr = 4'd7;
    bc_status = 2'b00; fill_mem();
    s0 = bc_start_cyc; e0 = eof_seen;
    pulse_start();
    wait_starts(s0 + 1);
    bc_status = 2'b01;
    tick(5);
    push_frame(6, 7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      input_rdy = 1'b1; tick(1); input_rdy = 1'b0; tick(2);
    end
    wait_eofs(e0 + 1);
    wait_starts(s0 + 2);
    tick(2);
    check("auto_rearm_timed_out", 32'(timed_out), 32'd0);
    check("auto_rearm_busy", 32'(busy), 32'd1);
    p0 = bc_stop_cyc;
    pulse_stop();
    tick(3);
    check("auto_abort_stop", 32'(bc_stop_cyc - p0), 32'd1);
    check("auto_abort_busy", 32'(busy), 32'd0);
    check("auto_abort_noframe", 32'(beat_q.size()), 32'd0);
    bc_status = 2'b00; auto_timeout = 16'd0;

    // Normal mode, stop arrives mid-frame.
    mode = 2'd1; num_samples = 16'd4; wr_ptr = 4'd3; fill_mem();
    s0 = bc_start_cyc; e0 = eof_seen; b0 = beats_seen;
    pulse_start();
    wait_starts(s0 + 1);
    tick(3);
    push_frame(4, 3, 1'b0);
    bc_status = 2'b11;
    for (int t = 0; t < 200 && beats_seen < b0 + 1; t++) tick(1);
    pulse_stop();
    wait_eofs(e0 + 1);
    tick(20);
    bc_status = 2'b00;
    check("normal_stop_starts", 32'(bc_start_cyc - s0), 32'd1);
    check("normal_stop_beats", 32'(beats_seen - b0), 32'd4);
    check("normal_stop_busy", 32'(busy), 32'd0);

    // Slow acknowledge: hold-until-ack and 3-cycle turnaround.
    ack_rand = 0; ack_delay = 5;
    run_frame(2'd0, 5, 9, 4);
    tick(5);
    ack_rand = 1;

    // Start and stop together, and a zero-length start, are both ignored.
    s0 = bc_start_cyc;
    rqst_start = 1'b1; rqst_stop = 1'b1; tick(1); rqst_start = 1'b0; rqst_stop = 1'b0;
    tick(10);
    check("start_stop_same_starts", 32'(bc_start_cyc - s0), 32'd0);
    check("start_stop_same_busy", 32'(busy), 32'd0);
    num_samples = 16'd0;
    pulse_start();
    tick(10);
    check("zero_len_starts", 32'(bc_start_cyc - s0), 32'd0);
    check("zero_len_busy", 32'(busy), 32'd0);

    // Length above depth clamps to a full-buffer frame.
    run_frame(2'd0, 20, int'($urandom_range(0, DEPTH - 1)), 3);
    tick(5);

    // Random single-shot frames (mode 0 and 3).
    for (int k = 0; k < 6; k++) begin
      n  = int'($urandom_range(1, DEPTH));
      wr = int'($urandom_range(0, DEPTH - 1));
      s0 = bc_start_cyc;
      run_frame(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, n, wr, int'($urandom_range(0, 10)));
      tick(8);
      check("rand_starts", 32'(bc_start_cyc - s0), 32'd1);
      check("rand_busy", 32'(busy), 32'd0);
    end

    // Reset while a sample is being offered.
    ack_rand = 0; ack_delay = 100;
    mode = 2'd1; num_samples = 16'd8; wr_ptr = 4'd5; fill_mem();
    s0 = bc_start_cyc;
    pulse_start();
    wait_starts(s0 + 1);
    tick(3);
    push_frame(8, 5, 1'b0);
    bc_status = 2'b11;
    for (int t = 0; t < 200 && !tx_rdy; t++) tick(1);
    check("pre_reset_rdy", 32'(tx_rdy), 32'd1);
    rst = 1'b1;
    tick(1);
    check_idle_outputs("midframe_reset");
    rst = 1'b0;
    bc_status = 2'b00;
    beat_q.delete();
    addr_q.delete();
    ack_rand = 1; ack_delay = 0;
    tick(10);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("sb_beats_left", 32'(beat_q.size()), 32'd0);
    check("sb_addrs_left", 32'(addr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Top-level acquisition scheduler for one ADC channel. It arms the buffer controller, waits for a triggered-and-full capture (or an auto-mode timeout), then stops capture and streams the last num_samples samples out of the circular sample RAM to tx_control. It re-arms automatically in normal and auto modes. It sits between the host request decoder, the buffer controller, the sample RAM read port and tx_control.

Parameters:
BITS_ADC, 8, sample width
ADDR_W, 12, sample RAM address width (depth 2^ADDR_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rqst_start  in  1  host request to begin acquisition (single-cycle pulse)
rqst_stop  in  1  host request to abort or stop re-arming (single-cycle pulse)
mode  in  2  0=single, 1=normal, 2=auto, 3 is treated as single
num_samples  in  16  samples per frame
auto_timeout  in  16  auto mode: input_rdy ticks to wait for a trigger
input_rdy  in  1  ADC sample strobe (timeout time base)
bc_start  out  1  one-cycle start pulse to buffer controller
bc_stop  out  1  one-cycle stop pulse to buffer controller
bc_status  in  2  {triggered, buffer_full} from buffer controller
wr_ptr  in  ADDR_W  next RAM write address (from RAM controller)
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  ADDR_W  RAM read address
ram_rd_data  in  BITS_ADC  read data, valid 1 cycle after ram_rd_en
tx_data  out  BITS_ADC  sample to tx_control
tx_rdy  out  1  tx_data valid
tx_eof  out  1  last sample of frame (qualified by tx_rdy)
tx_ack  in  1  tx_control accepts tx_data
busy  out  1  high in every state except IDLE
timed_out  out  1  last frame was sent without a trigger (auto mode)

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-frame abandons the frame with no eof.
- num_samples is clamped to 2^ADDR_W. If num_samples==0, rqst_start is ignored.
- States and transitions:
  - IDLE: rqst_start -> ARM.
  - ARM: bc_start=1 for exactly 1 cycle; clear the timeout counter and timed_out; go to GUARD.
  - GUARD: 2 cycles during which bc_status is ignored (stale flags); then -> WAIT_FULL.
  - WAIT_FULL: bc_status==2'b11 -> STOP. In auto mode, the timeout counter increments on each input_rdy; when count==auto_timeout and bc_status[0]==1 (buffer_full), set timed_out=1 and go to STOP. auto_timeout==0 disables the timeout.
  - STOP: bc_stop=1 for 1 cycle; latch base = wr_ptr - num_samples (mod 2^ADDR_W); load remaining = num_samples; -> READ.
  - READ: ram_rd_en=1 with ram_rd_addr=base; -> WAIT_DATA.
  - WAIT_DATA: register ram_rd_data into tx_data; -> SEND.
  - SEND: tx_rdy=1; tx_eof=1 when remaining==1. tx_data, tx_rdy and tx_eof stay stable until tx_ack.
    - On tx_ack: tx_rdy and tx_eof drop next cycle; base increments with wrap; remaining decrements.
    - remaining==1 at ack -> DONE, else -> READ.
    - Sample-to-sample: ack at cycle t gives the next tx_rdy at t+3.
  - DONE: mode normal/auto and no pending stop -> ARM; else -> IDLE.
- rqst_stop:
  - In ARM, GUARD or WAIT_FULL: pulse bc_stop and go to IDLE; no frame is sent.
  - In STOP..SEND: set stop_pending; the frame completes, then DONE -> IDLE.
  - In IDLE: no effect.
- rqst_start and rqst_stop in the same cycle: stop wins.
- rqst_start outside IDLE: ignored.
- tx_ack while tx_rdy==0: ignored.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W; wrap from all-ones to 0 is required.

Decomposition:
- Shared package acq_pkg holds mode codes MODE_SINGLE/MODE_NORMAL/MODE_AUTO, state encodings, and the GUARD_CYCLES=2 constant.
- One natural sub-module, frame_reader, owns READ/WAIT_DATA/SEND: base/remaining load, RAM read, and the tx handshake. It returns a done pulse to the top FSM.

Test Plan:
- Single mode, num_samples=4, wr_ptr=10, bc_status=11 after 20 cycles -> one bc_start, one bc_stop; ram_rd_addr 6,7,8,9; 4 tx beats; tx_eof on beat 4; busy falls; no re-arm.
- Wrap: ADDR_W=4, wr_ptr=2, num_samples=5 -> addresses 13,14,15,0,1.
- Auto mode, auto_timeout=8, bc_status=01, 8 input_rdy pulses -> STOP; timed_out=1; frame sent; then ARM re-entered with timed_out cleared.
- Normal mode, rqst_stop during beat 2 of 4 -> all 4 beats complete with eof; then IDLE and no further bc_start.
- tx_ack delayed 5 cycles per beat -> tx_data, tx_rdy, tx_eof stable until ack; the next tx_rdy is exactly 3 cycles after each ack.
- rqst_start and rqst_stop in the same cycle from IDLE -> stays IDLE, no bc_start. Reset asserted during SEND -> all outputs 0 the next cycle.
